multdiv_scheduler: RTL and testbench
====================================

# multdiv_scheduler

Sequences the multi-cycle multiply/divide unit on behalf of the single-cycle processor. It latches a decoded mul/div, starts the unit, and stalls the processor until the result returns. It then arbitrates the result onto the regfile write port, which the processor's own writes own by priority. On an exception it writes rstatus (r30) instead of rd.

## Interface
- MAX_LAT, 40: maximum WAIT cycles before timeout; legal 2..63.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- issue_valid  in  1  processor decoded mul/div this cycle.
- issue_op  in  1  0 = mul, 1 = div.
- issue_rd  in  5  destination register.
- issue_a, issue_b  in  32  operands (regfile A/B read data).
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses to the multdiv unit.
- md_operandA, md_operandB  out  32  latched operands, held stable from START until IDLE.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv overflow / divide-by-zero.
- md_resultRDY  in  1  result valid, single-cycle pulse.
- stall  out  1  freeze PC and processor state.
- wb_req  out  1  regfile write request.
- wb_reg  out  5  write address.
- wb_data  out  32  write data.
- wb_grant  in  1  regfile port free this cycle; the processor's own write has priority.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, START, WAIT, WB.
- **IDLE**
  - On issue_valid, latch op, rd, a, b and go to START.
  - issue_valid is ignored in every other state.
- **START**
  - Drive exactly one of md_ctrl_mult / md_ctrl_div high (per op) for this single cycle.
  - Clear the wait counter; go to WAIT.
  - md_resultRDY is not sampled here.
- **WAIT**
  - Counter increments each cycle.
  - On md_resultRDY, latch md_result and md_exception, then go to WB.
  - Timeout: if counter == MAX_LAT-1 and RDY is low, set timeout_err and latch exception=1, result=0; go to WB. A RDY arriving on the MAX_LAT-th wait cycle is accepted normally.
- **WB** (write target)
  - exception=1: wb_reg=30, wb_data=4 for mul or 5 for div. rd is not written.
  - exception=0 and rd≠0: wb_reg=rd, wb_data=result.
  - exception=0 and rd=0: no write. wb_req stays low and the block goes directly to IDLE from WAIT instead of entering WB.
- **WB** (handshake)
  - wb_req stays high with wb_reg and wb_data stable until a cycle with wb_grant=1.
  - Go to IDLE on the edge ending that cycle.
- stall = issue_valid (when IDLE) OR state≠IDLE. This is combinational, so the processor freezes in the issue cycle itself.
- Reset (async, any state): state=IDLE, counter=0, all latched data=0, timeout_err=0. An in-flight multdiv result arriving after reset is ignored.

## Timing
- Reset values of all outputs are 0: md_ctrl_*, md_operand*, stall (issue_valid permitting), wb_req, wb_reg, wb_data, busy, timeout_err.
- Cycle 0: issue_valid=1, stall=1.
- Cycle 1: START, ctrl pulse.
- Cycle 2 onward: WAIT.
- RDY in wait cycle n puts WB in the next cycle. Minimum issue-to-wb_req latency is 3 cycles.
- With grant in the first WB cycle, stall is high for 4 cycles minimum (cycles 0–3) and low in cycle 4.
- The rd=0 / no-exception case returns to IDLE one cycle after RDY; stall is high for 3 cycles minimum.
- wb_req, wb_reg and wb_data are registered (state-decoded from latched data) and glitch-free during the grant wait.
- Timeout raises timeout_err on the edge after wait cycle MAX_LAT. It stays high through later operations.

## Test plan
- **mul, normal**
  - Stimulus: mul a=7, b=6, rd=5; RDY with 42 in the 3rd WAIT cycle; grant=1.
  - Required: single md_ctrl_mult pulse in cycle 1; md_ctrl_div never high; wb_req with r5=42 in cycle 5; stall high cycles 0–5, low in cycle 6.
- **div, exception**
  - Stimulus: div a=9, b=0, rd=7; RDY with md_exception=1.
  - Required: wb_reg=30, wb_data=5; r7 never requested.
- **rd=0**
  - Stimulus: mul with rd=0, no exception.
  - Required: wb_req never asserts; busy drops the cycle after RDY.
- **grant wait**
  - Stimulus: wb_grant held low 3 WB cycles, then high.
  - Required: wb_req, wb_reg and wb_data are held constant for 4 cycles; stall is high throughout; IDLE follows.
- **timeout**
  - Stimulus: MAX_LAT=8, mul, RDY never asserted.
  - Required: timeout_err=1 after 8 WAIT cycles; WB writes r30=4; a second normal mul still completes with timeout_err still 1.
- **reset mid-op**
  - Stimulus: reset driven low in WAIT, released, then a late RDY pulse.
  - Required: all outputs 0 immediately without a clock edge; the late RDY is ignored; wb_req stays 0.

Source files
------------

// File: rtl/multdiv_scheduler_if.sv
// Bundles the processor issue port, the multdiv unit handshake and the regfile
// write-back port of the multdiv scheduler.
interface multdiv_scheduler_if;
  logic        issue_valid;
  logic        issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;

  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  logic        stall;
  logic        wb_req;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_grant;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  issue_valid, issue_op, issue_rd, issue_a, issue_b,
    input  md_result, md_exception, md_resultRDY, wb_grant,
    output md_ctrl_mult, md_ctrl_div, md_operandA, md_operandB,
    output stall, wb_req, wb_reg, wb_data, busy, timeout_err
  );

  modport master (
    output issue_valid, issue_op, issue_rd, issue_a, issue_b,
    output md_result, md_exception, md_resultRDY, wb_grant,
    input  md_ctrl_mult, md_ctrl_div, md_operandA, md_operandB,
    input  stall, wb_req, wb_reg, wb_data, busy, timeout_err
  );
endinterface

// File: rtl/multdiv_scheduler.sv
// Runs one mul/div on the multi-cycle unit while stalling the processor, then
// arbitrates the result (or the rstatus exception code) onto the regfile port.
module multdiv_scheduler #(
  parameter int MAX_LAT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  localparam logic [5:0] LAST_WAIT = 6'(MAX_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic        op_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic [5:0]  count;
  logic        timeout_q;
  logic        timeout_hit;

  // Last permitted wait cycle passed with no result from the unit.
  assign timeout_hit = (state == WAIT) && !bus.md_resultRDY && (count == LAST_WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.issue_valid) next_state = START;
      START: next_state = WAIT;
      WAIT: begin
        if (bus.md_resultRDY)
          next_state = (bus.md_exception || (rd_q != 5'd0)) ? WB : IDLE;
        else if (timeout_hit)
          next_state = WB;
      end
      WB:    if (bus.wb_grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= 1'b0;
      rd_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      count     <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            op_q <= bus.issue_op;
            rd_q <= bus.issue_rd;
            a_q  <= bus.issue_a;
            b_q  <= bus.issue_b;
          end
        end
        START: count <= 6'd0;
        WAIT: begin
          count <= count + 6'd1;
          if (bus.md_resultRDY) begin
            result_q <= bus.md_result;
            exc_q    <= bus.md_exception;
          end else if (timeout_hit) begin
            result_q  <= 32'd0;
            exc_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back fields decode only flopped state, so they hold still while waiting for grant.
  always_comb begin
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.wb_req       = 1'b0;
    bus.wb_reg       = 5'd0;
    bus.wb_data      = 32'd0;
    case (state)
      START: begin
        bus.md_ctrl_mult = !op_q;
        bus.md_ctrl_div  = op_q;
      end
      WB: begin
        bus.wb_req = 1'b1;
        if (exc_q) begin
          bus.wb_reg  = 5'd30;
          bus.wb_data = op_q ? 32'd5 : 32'd4;
        end else begin
          bus.wb_reg  = rd_q;
          bus.wb_data = result_q;
        end
      end
      default: ;
    endcase
    bus.busy  = (state != IDLE);
    bus.stall = (state != IDLE) || bus.issue_valid;
  end

  assign bus.md_operandA = a_q;
  assign bus.md_operandB = b_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: expected write-backs go into a queue that a
// negedge monitor drains on every granted wb_req.
module tb_multdiv_scheduler;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  wb_t  expected_q[$];
  wb_t  exp_wb;

  multdiv_scheduler_if bus();

  multdiv_scheduler #(.MAX_LAT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue in the current (IDLE) cycle; returns one cycle later, in START.
  task automatic apply_stimulus(input logic op, input logic [4:0] rd, input logic [31:0] a,
                                input logic [31:0] b, input bit expect_wb,
                                input logic [4:0] exp_addr, input logic [31:0] exp_data);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_rd    = rd;
    bus.issue_a     = a;
    bus.issue_b     = b;
    if (expect_wb) expected_q.push_back('{addr: exp_addr, data: exp_data});
    #1;
    check_bit("issue_stall", bus.stall, 1'b1);
    tick();
    bus.issue_valid = 1'b0;
    #1;
  endtask

  task automatic check_wb(input string name, input logic [4:0] addr, input logic [31:0] data);
    check_bit({name, "_req"}, bus.wb_req, 1'b1);
    check_output({name, "_reg"}, {27'd0, bus.wb_reg}, {27'd0, addr});
    check_output({name, "_data"}, bus.wb_data, data);
  endtask

  always @(negedge clock) begin
    if (reset && bus.wb_req && bus.wb_grant) begin
      if (expected_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got r%0d=%0h, expected no write", bus.wb_reg, bus.wb_data);
      end else begin
        exp_wb = expected_q.pop_front();
        check_output("sb_wb_reg", {27'd0, bus.wb_reg}, {27'd0, exp_wb.addr});
        check_output("sb_wb_data", bus.wb_data, exp_wb.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_op     = 1'b0;
    bus.issue_rd     = 5'd0;
    bus.issue_a      = 32'd0;
    bus.issue_b      = 32'd0;
    bus.md_result    = 32'd0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.wb_grant     = 1'b0;
    #2;
    check_bit("rst_mult", bus.md_ctrl_mult, 1'b0);
    check_bit("rst_div", bus.md_ctrl_div, 1'b0);
    check_output("rst_opA", bus.md_operandA, 32'd0);
    check_output("rst_opB", bus.md_operandB, 32'd0);
    check_bit("rst_stall", bus.stall, 1'b0);
    check_bit("rst_wb_req", bus.wb_req, 1'b0);
    check_output("rst_wb_reg", {27'd0, bus.wb_reg}, 32'd0);
    check_output("rst_wb_data", bus.wb_data, 32'd0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_timeout", bus.timeout_err, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    $display("[TB] mul normal");
    apply_stimulus(1'b0, 5'd5, 32'd7, 32'd6, 1'b1, 5'd5, 32'd42);
    check_bit("mul_start_mult", bus.md_ctrl_mult, 1'b1);
    check_bit("mul_start_div", bus.md_ctrl_div, 1'b0);
    check_output("mul_opA", bus.md_operandA, 32'd7);
    check_output("mul_opB", bus.md_operandB, 32'd6);
    check_bit("mul_stall_c1", bus.stall, 1'b1);
    tick();
    check_bit("mul_pulse_end", bus.md_ctrl_mult, 1'b0);
    check_bit("mul_div_c2", bus.md_ctrl_div, 1'b0);
    check_bit("mul_busy_c2", bus.busy, 1'b1);
    tick();
    check_bit("mul_stall_c3", bus.stall, 1'b1);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd42;
    bus.wb_grant     = 1'b1;
    #1;
    check_bit("mul_no_early_wb", bus.wb_req, 1'b0);
    check_bit("mul_stall_c4", bus.stall, 1'b1);
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_wb("mul_wb_c5", 5'd5, 32'd42);
    check_bit("mul_stall_c5", bus.stall, 1'b1);
    tick();
    check_bit("mul_stall_c6", bus.stall, 1'b0);
    check_bit("mul_busy_c6", bus.busy, 1'b0);
    check_bit("mul_wb_done", bus.wb_req, 1'b0);

    $display("[TB] div exception");
    tick();
    apply_stimulus(1'b1, 5'd7, 32'd9, 32'd0, 1'b1, 5'd30, 32'd5);
    check_bit("div_start_div", bus.md_ctrl_div, 1'b1);
    check_bit("div_start_mult", bus.md_ctrl_mult, 1'b0);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_exception = 1'b1;
    bus.md_result    = 32'hdead_beef;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_wb("div_exc_wb", 5'd30, 32'd5);
    tick();
    check_bit("div_idle", bus.busy, 1'b0);

    $display("[TB] rd=0");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'd3, 32'd3, 1'b0, 5'd0, 32'd0);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd9;
    #1;
    check_bit("rd0_busy_rdy", bus.busy, 1'b1);
    check_bit("rd0_no_req_rdy", bus.wb_req, 1'b0);
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_bit("rd0_busy_drop", bus.busy, 1'b0);
    check_bit("rd0_no_req", bus.wb_req, 1'b0);
    check_bit("rd0_stall_drop", bus.stall, 1'b0);

    $display("[TB] grant wait");
    bus.wb_grant = 1'b0;
    tick();
    apply_stimulus(1'b0, 5'd3, 32'd2, 32'd3, 1'b1, 5'd3, 32'd6);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd6;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.wb_grant = 1'b1;
      #1;
      check_wb("gw_hold", 5'd3, 32'd6);
      check_bit("gw_stall", bus.stall, 1'b1);
      tick();
    end
    check_bit("gw_idle", bus.busy, 1'b0);
    check_bit("gw_req_low", bus.wb_req, 1'b0);

    $display("[TB] rdy on last wait cycle");
    tick();
    apply_stimulus(1'b0, 5'd6, 32'd7, 32'd11, 1'b1, 5'd6, 32'd77);
    repeat (7) tick();
    check_bit("late_busy", bus.busy, 1'b1);
    check_bit("late_no_req", bus.wb_req, 1'b0);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd77;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_wb("late_wb", 5'd6, 32'd77);
    check_bit("late_no_timeout", bus.timeout_err, 1'b0);
    tick();

    $display("[TB] timeout");
    tick();
    apply_stimulus(1'b0, 5'd9, 32'd4, 32'd4, 1'b1, 5'd30, 32'd4);
    repeat (8) tick();
    check_bit("to_not_yet", bus.timeout_err, 1'b0);
    check_bit("to_busy", bus.busy, 1'b1);
    check_bit("to_no_req", bus.wb_req, 1'b0);
    tick();
    check_bit("to_flag", bus.timeout_err, 1'b1);
    check_wb("to_wb", 5'd30, 32'd4);
    tick();
    check_bit("to_idle", bus.busy, 1'b0);
    tick();
    apply_stimulus(1'b0, 5'd4, 32'd3, 32'd5, 1'b1, 5'd4, 32'd15);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd15;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_wb("to_second_wb", 5'd4, 32'd15);
    check_bit("to_sticky", bus.timeout_err, 1'b1);
    tick();
    check_bit("to_sticky_idle", bus.timeout_err, 1'b1);

    $display("[TB] reset mid-op");
    tick();
    apply_stimulus(1'b0, 5'd8, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    check_bit("rm_busy_before", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("rm_busy", bus.busy, 1'b0);
    check_bit("rm_stall", bus.stall, 1'b0);
    check_output("rm_opA", bus.md_operandA, 32'd0);
    check_output("rm_opB", bus.md_operandB, 32'd0);
    check_bit("rm_wb_req", bus.wb_req, 1'b0);
    check_bit("rm_timeout", bus.timeout_err, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd123;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_result    = 32'd0;
    #1;
    check_bit("rm_late_rdy_req", bus.wb_req, 1'b0);
    check_bit("rm_late_rdy_busy", bus.busy, 1'b0);
    tick();
    check_bit("rm_still_no_req", bus.wb_req, 1'b0);

    check_output("sb_drained", expected_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
